// File: rtl/datapath_mc_pkg.sv
// Shared encodings for the multi-cycle datapath: register-source selects and
// the memory handshake FSM state.
package datapath_mc_pkg;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_ALU  = 2'd2,
    PC_RFA  = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    MA_HOLD  = 2'd0,
    MA_PC    = 2'd1,
    MA_ALU   = 2'd2,
    MA_HOLD3 = 2'd3
  } ma_sel_e;

  typedef enum logic [2:0] {
    RF_NONE = 3'd0,
    RF_ALU  = 3'd1,
    RF_HI   = 3'd2,
    RF_LO   = 3'd3,
    RF_MD   = 3'd4
  } rf_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/datapath_mc_rf_param.sv
// Register file: two combinational read ports, one clocked write port,
// register 0 hard-wired to zero.
module rf_param #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 we,
  input  logic [RF_ADDR_W-1:0] a_addr,
  input  logic [RF_ADDR_W-1:0] b_addr,
  input  logic [RF_ADDR_W-1:0] z_addr,
  input  logic [DATA_W-1:0]    z_data,
  output logic [DATA_W-1:0]    a_data,
  output logic [DATA_W-1:0]    b_data
);

  localparam int NREG = 1 << RF_ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (we && (z_addr != '0)) regs_d[z_addr] = z_data;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign a_data = (a_addr == '0) ? '0 : regs_q[a_addr];
  assign b_data = (b_addr == '0) ? '0 : regs_q[b_addr];

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle CPU datapath: PC/MA/MD/IR/HI/LO registers, register file,
// ALU operand muxing and a req/ack memory handshake with timeout.
module datapath_mc
  import datapath_mc_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 4,
  parameter int PC_STEP   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [1:0]           pc_sel,
  input  logic [1:0]           ma_sel,
  input  logic                 md_sel,
  input  logic                 alu_a_sel,
  input  logic                 alu_b_sel,
  input  logic [2:0]           rf_sel,
  input  logic [RF_ADDR_W-1:0] rf_a_addr,
  input  logic [RF_ADDR_W-1:0] rf_b_addr,
  input  logic [RF_ADDR_W-1:0] rf_z_addr,
  input  logic                 ir_en,
  input  logic                 hi_en,
  input  logic                 lo_en,
  input  logic [DATA_W-1:0]    constant_c,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  input  logic [DATA_W-1:0]    alu_z,
  input  logic [DATA_W-1:0]    alu_hi,
  input  logic [DATA_W-1:0]    alu_lo,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy,
  output logic                 mem_err,
  output logic [DATA_W-1:0]    ir_out
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [DATA_W-1:0] pc_q, pc_d, ma_q, ma_d, md_q, md_d;
  logic [DATA_W-1:0] ir_q, ir_d, hi_q, hi_d, lo_q, lo_d;
  logic [DATA_W-1:0] rf_a_data, rf_b_data, rf_wdata;
  logic              rf_we, rd_done;
  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d, cnt_inc;
  logic              mem_err_q, mem_err_d;

  rf_param #(.DATA_W(DATA_W), .RF_ADDR_W(RF_ADDR_W)) u_rf (
    .clk    (clk),
    .clr    (clr),
    .we     (rf_we),
    .a_addr (rf_a_addr),
    .b_addr (rf_b_addr),
    .z_addr (rf_z_addr),
    .z_data (rf_wdata),
    .a_data (rf_a_data),
    .b_data (rf_b_data)
  );

  assign rd_done = (state_q == ST_READ) && mem_ack;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel_e'(pc_sel))
      PC_INC:  pc_d = pc_q + DATA_W'(PC_STEP);
      PC_ALU:  pc_d = alu_z;
      PC_RFA:  pc_d = rf_a_data;
      default: pc_d = pc_q;
    endcase

    ma_d = ma_q;
    case (ma_sel_e'(ma_sel))
      MA_PC:   ma_d = pc_q;
      MA_ALU:  ma_d = alu_z;
      default: ma_d = ma_q;
    endcase

    // A finishing read owns MD even if the control unit also asks for rf_b.
    md_d = md_q;
    if (rd_done)     md_d = mem_rdata;
    else if (md_sel) md_d = rf_b_data;

    ir_d = ir_en ? md_q   : ir_q;
    hi_d = hi_en ? alu_hi : hi_q;
    lo_d = lo_en ? alu_lo : lo_q;

    rf_we    = 1'b1;
    rf_wdata = '0;
    case (rf_sel_e'(rf_sel))
      RF_ALU:  rf_wdata = alu_z;
      RF_HI:   rf_wdata = hi_q;
      RF_LO:   rf_wdata = lo_q;
      RF_MD:   rf_wdata = md_q;
      default: rf_we = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    cnt_inc    = wait_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (mem_rd) begin
          state_d   = ST_READ;
          mem_err_d = mem_wr;
        end else if (mem_wr) begin
          state_d = ST_WRITE;
        end
      end
      ST_READ, ST_WRITE: begin
        if (mem_ack) begin
          state_d    = ST_IDLE;
          wait_cnt_d = '0;
        end else if (TIMEOUT > 0) begin
          if (cnt_inc == CNT_W'(TIMEOUT)) begin
            state_d    = ST_IDLE;
            wait_cnt_d = '0;
            mem_err_d  = 1'b1;
          end else begin
            wait_cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q       <= '0;
      ma_q       <= '0;
      md_q       <= '0;
      ir_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      ma_q       <= ma_d;
      md_q       <= md_d;
      ir_q       <= ir_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign alu_a     = alu_a_sel ? pc_q : rf_a_data;
  assign alu_b     = alu_b_sel ? constant_c : rf_b_data;
  assign mem_req   = (state_q != ST_IDLE);
  assign mem_we    = (state_q == ST_WRITE);
  assign busy      = mem_req;
  assign mem_err   = mem_err_q;
  assign mem_addr  = ma_q;
  assign mem_wdata = md_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_datapath_mc.sv
// Directed self-checking bench for datapath_mc: PC stepping/wrap, register
// file, HI/LO/IR paths, memory handshake, timeout, dual start and async reset.
module tb_datapath_mc;

  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  pc_sel, ma_sel;
  logic        md_sel, alu_a_sel, alu_b_sel;
  logic [2:0]  rf_sel;
  logic [3:0]  rf_a_addr, rf_b_addr, rf_z_addr;
  logic        ir_en, hi_en, lo_en;
  logic [31:0] constant_c, alu_z, alu_hi, alu_lo, mem_rdata;
  logic        mem_rd, mem_wr, mem_ack;
  logic [31:0] alu_a, alu_b, mem_addr, mem_wdata, ir_out;
  logic        mem_req, mem_we, busy, mem_err;

  int checks = 0;
  int errors = 0;
  int busy_cycles, err_cnt, we_seen, err_seen;

  datapath_mc dut (
    .clk(clk), .clr(clr), .pc_sel(pc_sel), .ma_sel(ma_sel), .md_sel(md_sel),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_sel(rf_sel),
    .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr), .rf_z_addr(rf_z_addr),
    .ir_en(ir_en), .hi_en(hi_en), .lo_en(lo_en), .constant_c(constant_c),
    .alu_a(alu_a), .alu_b(alu_b), .alu_z(alu_z), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .busy(busy), .mem_err(mem_err), .ir_out(ir_out)
  );

  always #5 clk = ~clk;

  task automatic clearControls();
    pc_sel = '0; ma_sel = '0; md_sel = 1'b0; alu_a_sel = 1'b0; alu_b_sel = 1'b0;
    rf_sel = '0; rf_a_addr = '0; rf_b_addr = '0; rf_z_addr = '0;
    ir_en = 1'b0; hi_en = 1'b0; lo_en = 1'b0;
    constant_c = '0; alu_z = '0; alu_hi = '0; alu_lo = '0; mem_rdata = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_ack = 1'b0;
  endtask

  // Clocks the currently driven controls in for n edges, then returns to idle controls.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    clearControls();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clearControls();
    clr = 1'b0;
    #3;
    alu_a_sel = 1'b1;
    #1;
    checkOutput("reset_pc", alu_a, 32'h0);
    checkOutput("reset_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_mem_err", {31'b0, mem_err}, 32'h0);
    checkOutput("reset_md", mem_wdata, 32'h0);
    checkOutput("reset_ir", ir_out, 32'h0);
    clearControls();
    @(negedge clk);
    clr = 1'b1;

    pc_sel = 2'd1;
    applyStimulus(3);
    alu_a_sel = 1'b1; #1;
    checkOutput("pc_step3", alu_a, 32'd12);
    applyStimulus(2);
    alu_a_sel = 1'b1; #1;
    checkOutput("pc_hold", alu_a, 32'd12);

    pc_sel = 2'd2; alu_z = 32'hFFFF_FFFC;
    applyStimulus(1);
    alu_a_sel = 1'b1; #1;
    checkOutput("pc_preload", alu_a, 32'hFFFF_FFFC);
    pc_sel = 2'd1;
    applyStimulus(1);
    alu_a_sel = 1'b1; #1;
    checkOutput("pc_wrap", alu_a, 32'h0);

    rf_sel = 3'd1; alu_z = 32'hDEAD_BEEF; rf_z_addr = 4'd5; rf_a_addr = 4'd5; #1;
    checkOutput("rf_old_on_write", alu_a, 32'h0);
    applyStimulus(1);
    rf_a_addr = 4'd5; #1;
    checkOutput("rf_r5", alu_a, 32'hDEAD_BEEF);
    rf_sel = 3'd1; alu_z = 32'h1234_5678; rf_z_addr = 4'd0;
    applyStimulus(1);
    rf_a_addr = 4'd0; rf_b_addr = 4'd5; #1;
    checkOutput("rf_r0_zero", alu_a, 32'h0);
    checkOutput("rf_r5_portb", alu_b, 32'hDEAD_BEEF);
    alu_b_sel = 1'b1; constant_c = 32'hFFFF_FF80; #1;
    checkOutput("alu_b_const", alu_b, 32'hFFFF_FF80);

    hi_en = 1'b1; alu_hi = 32'hAAAA_0000; lo_en = 1'b1; alu_lo = 32'h0000_BBBB;
    applyStimulus(1);
    rf_sel = 3'd2; rf_z_addr = 4'd6;
    applyStimulus(1);
    rf_sel = 3'd3; rf_z_addr = 4'd7;
    applyStimulus(1);
    rf_sel = 3'd6; rf_z_addr = 4'd7; alu_z = 32'h9999_9999;
    applyStimulus(1);
    rf_a_addr = 4'd6; rf_b_addr = 4'd7; #1;
    checkOutput("rf_from_hi", alu_a, 32'hAAAA_0000);
    checkOutput("rf_from_lo_sel6_none", alu_b, 32'h0000_BBBB);

    ma_sel = 2'd2; alu_z = 32'h100;
    applyStimulus(1);
    checkOutput("ma_load", mem_addr, 32'h100);
    mem_rd = 1'b1;
    applyStimulus(1);
    checkOutput("read_busy", {31'b0, busy}, 32'h1);
    checkOutput("read_we_low", {31'b0, mem_we}, 32'h0);
    busy_cycles = 0; err_seen = 0;
    for (int i = 0; i < 8 && busy; i++) begin
      if (i == 3) begin
        mem_ack = 1'b1; mem_rdata = 32'h1234; md_sel = 1'b1; rf_b_addr = 4'd5;
      end
      busy_cycles++;
      if (mem_err) err_seen++;
      applyStimulus(1);
    end
    checkOutput("read_busy_cycles", busy_cycles, 32'd4);
    checkOutput("read_md", mem_wdata, 32'h1234);
    checkOutput("read_no_err", err_seen + {31'b0, mem_err}, 32'h0);
    checkOutput("read_ma_kept", mem_addr, 32'h100);

    mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
    applyStimulus(1);
    checkOutput("idle_ack_busy", {31'b0, busy}, 32'h0);
    checkOutput("idle_ack_md", mem_wdata, 32'h1234);

    rf_sel = 3'd1; alu_z = 32'h55; rf_z_addr = 4'd8;
    applyStimulus(1);
    md_sel = 1'b1; rf_b_addr = 4'd8;
    applyStimulus(1);
    checkOutput("md_from_rf", mem_wdata, 32'h55);
    mem_wr = 1'b1;
    applyStimulus(1);
    checkOutput("write_we", {31'b0, mem_we}, 32'h1);
    busy_cycles = 0; err_cnt = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      if (i == 2) mem_rd = 1'b1;
      busy_cycles++;
      if (mem_err) err_cnt++;
      applyStimulus(1);
    end
    repeat (3) begin
      if (mem_err) err_cnt++;
      applyStimulus(1);
    end
    checkOutput("timeout_busy_cycles", busy_cycles, 32'd16);
    checkOutput("timeout_err_pulses", err_cnt, 32'd1);
    checkOutput("timeout_idle", {31'b0, busy}, 32'h0);
    checkOutput("timeout_md_kept", mem_wdata, 32'h55);

    mem_rd = 1'b1; mem_wr = 1'b1;
    applyStimulus(1);
    busy_cycles = 0; err_cnt = 0; we_seen = 0;
    for (int i = 0; i < 8 && busy; i++) begin
      if (i == 1) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      end
      busy_cycles++;
      if (mem_err) err_cnt++;
      if (mem_we) we_seen++;
      applyStimulus(1);
    end
    repeat (2) begin
      if (mem_err) err_cnt++;
      applyStimulus(1);
    end
    checkOutput("dual_busy_cycles", busy_cycles, 32'd2);
    checkOutput("dual_md_read", mem_wdata, 32'hCAFE_F00D);
    checkOutput("dual_no_we", we_seen, 32'd0);
    checkOutput("dual_err_pulses", err_cnt, 32'd1);

    ir_en = 1'b1;
    applyStimulus(1);
    checkOutput("ir_load", ir_out, 32'hCAFE_F00D);

    mem_rd = 1'b1;
    applyStimulus(1);
    checkOutput("abort_busy_before", {31'b0, busy}, 32'h1);
    #2 clr = 1'b0;
    #1;
    checkOutput("abort_mem_req", {31'b0, mem_req}, 32'h0);
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    checkOutput("abort_md", mem_wdata, 32'h0);
    checkOutput("abort_ir", ir_out, 32'h0);
    mem_rd = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    applyStimulus(1);
    checkOutput("held_reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("held_reset_md", mem_wdata, 32'h0);
    @(negedge clk);
    clr = 1'b1;
    rf_a_addr = 4'd5; alu_a_sel = 1'b0; #1;
    checkOutput("reset_rf_r5", alu_a, 32'h0);
    mem_rd = 1'b1;
    applyStimulus(1);
    checkOutput("restart_busy", {31'b0, busy}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_mc.md
DATAPATH_MC -- requirements
Module: datapath_mc

Interface
REQ-001 Parameter DATA_W, 32, datapath/register width in bits.
REQ-002 Parameter RF_ADDR_W, 4, register file address width (2^RF_ADDR_W registers).
REQ-003 Parameter PC_STEP, 4, PC increment value.
REQ-004 Parameter TIMEOUT, 16, memory wait-cycle limit (0 disables the timeout).
REQ-005 Port list (name, direction, width, meaning), one port per entry:
- clk  in  1  the only clock; rising edge.
- clr  in  1  reset, asynchronous, active-low.
- pc_sel  in  2  PC source: 0 hold, 1 PC+PC_STEP, 2 alu_z, 3 rf_a.
- ma_sel  in  2  MA source: 0 hold, 1 PC, 2 alu_z, 3 hold.
- md_sel  in  1  load MD from rf_b.
- alu_a_sel  in  1  ALU A operand: 0 rf_a, 1 PC.
- alu_b_sel  in  1  ALU B operand: 0 rf_b, 1 constant_c.
- rf_sel  in  3  RF write source: 0 none, 1 alu_z, 2 HI, 3 LO, 4 MD, 5–7 none.
- rf_a_addr, rf_b_addr, rf_z_addr  in  RF_ADDR_W  read A, read B and write addresses.
- ir_en, hi_en, lo_en  in  1  load IR from MD, HI from alu_hi, LO from alu_lo.
- constant_c  in  DATA_W  sign-extended immediate.
- alu_a, alu_b  out  DATA_W  operands to the external alu.
- alu_z, alu_hi, alu_lo  in  DATA_W  results from the external alu.
- mem_rd, mem_wr  in  1  single-cycle start pulses for a memory read/write.
- mem_req, mem_we  out  1  bus request and write qualifier.
- mem_addr, mem_wdata  out  DATA_W  equal to MA and MD.
- mem_ack  in  1  bus completion.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  memory transaction in progress.
- mem_err  out  1  one-cycle error pulse.
- ir_out  out  DATA_W  IR contents.

Function
REQ-006 PC, MA, MD, IR, HI and LO shall update only on the rising clk edge, per their select or enable inputs; otherwise they hold.
REQ-007 PC+PC_STEP shall wrap modulo 2^DATA_W (0xFFFFFFFC+4 = 0 at defaults).
REQ-008 Register 0 shall always read as zero; writes to address 0 shall be discarded.
REQ-009 RF reads shall be combinational.
REQ-010 An RF write shall be visible on the next cycle.
REQ-011 A same-cycle read of the register being written shall return the old value.
REQ-012 The memory FSM shall have three states: IDLE, READ and WRITE.
REQ-013 In IDLE, mem_rd shall move the FSM to READ and mem_wr shall move it to WRITE on the next edge.
REQ-014 mem_req shall be 1 only in READ or WRITE.
REQ-015 mem_we shall be 1 only in WRITE.
REQ-016 busy shall equal mem_req.
REQ-017 In READ with mem_ack=1, MD shall load mem_rdata and the FSM shall return to IDLE.
REQ-018 In WRITE with mem_ack=1, the FSM shall return to IDLE.
REQ-019 Minimum transaction latency shall be 2 cycles from the start pulse to IDLE.
REQ-020 mem_rd and mem_wr in the same IDLE cycle shall start a read and drop the write.
REQ-021 That dual-start case shall also pulse mem_err for one cycle.
REQ-022 mem_rd or mem_wr while busy=1 shall be ignored without error.
REQ-023 An MD update from read completion shall take priority over md_sel in the same cycle.
REQ-024 With TIMEOUT>0, a wait counter shall reset on entry to READ/WRITE and increment each cycle without mem_ack.
REQ-025 When the counter reaches TIMEOUT, the FSM shall return to IDLE with MD unchanged and pulse mem_err for one cycle.
REQ-026 mem_ack in IDLE shall be ignored.
REQ-027 ma_sel and pc_sel shall remain effective while busy; the control unit is responsible for holding MA stable.

Reset
REQ-028 While clr=0, the following shall read 0 regardless of clk: PC, MA, MD, IR, HI, LO, all RF registers, the wait counter, mem_req, mem_we, busy and mem_err.
REQ-029 While clr=0, the FSM shall be in IDLE regardless of clk.
REQ-030 clr asserted mid-transaction shall abort the transaction immediately, with no MD update.
REQ-031 The first transaction shall start no earlier than the first edge after clr rises.

Structure
REQ-032 A shared package shall hold the pc_sel, ma_sel and rf_sel encodings and the FSM state typedef.
REQ-033 The register file shall be one sub-module, rf_param, parametrised by DATA_W and RF_ADDR_W.
REQ-034 The ALU shall remain external to this block.

Verification
REQ-035 Reset then pc_sel=1 for 3 cycles -> PC=12.
REQ-036 PC preloaded 0xFFFFFFFC, then pc_sel=1 -> PC=0.
REQ-037 Write 0xDEADBEEF to r5, then to r0 -> r5 reads 0xDEADBEEF; r0 reads 0.
REQ-038 MA=0x100, mem_rd, mem_ack after 3 wait cycles with rdata=0x1234 -> busy high 4 cycles; MD=0x1234; mem_err=0.
REQ-039 mem_wr with MD=0x55; mem_ack withheld for TIMEOUT=16 cycles -> mem_err pulses once; FSM returns to IDLE; MD=0x55.
REQ-040 mem_rd and mem_wr in the same cycle -> read performed, mem_we never 1, mem_err pulses once.
REQ-041 clr pulled low during READ -> mem_req falls with no clock edge; MD=0.
